// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with the 16-op alu_sel encoding, an iterative
// shift-add multiplier and a restoring divider, both producing double-width
// results, plus zero and divide-by-zero flags.
//
// Handshakes: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// and out_valid come only from the state register, and the requester must
// hold in_valid and its operands until the transfer happens.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       alu_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] alu_out_hi,
   output logic             c_out,
   output logic             zero,
   output logic             div_by_zero,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;      // MUL partial-product high / DIV remainder
   logic [WIDTH-1:0] lo_q, lo_d;      // MUL multiplier+low product / DIV quotient
   logic             div_op_q, div_op_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] out_hi_q, out_hi_d;
   logic             c_q, c_d;
   logic             zero_q, zero_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] one_res, one_hi;
   logic             one_c, one_dbz;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic             div_ge;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic             needs_calc;

   // Single-step result straight from the request operands (used at accept).
   always_comb begin
      sum_ext = {1'b0, A} + {1'b0, B};
      one_res = '0;
      one_hi  = '0;
      one_c   = 1'b0;
      one_dbz = 1'b0;
      case (alu_sel)
         4'h0: begin one_res = sum_ext[WIDTH-1:0]; one_c = sum_ext[WIDTH]; end
         4'h1: begin one_res = A - B; one_c = (A < B); end
         4'h3: begin one_res = '1; one_hi = A; one_dbz = 1'b1; end // only B == 0 lands here
         4'h4: begin one_res = {A[WIDTH-2:0], 1'b0}; one_c = A[WIDTH-1]; end
         4'h5: begin one_res = {1'b0, A[WIDTH-1:1]}; one_c = A[0]; end
         4'h6: begin one_res = {A[WIDTH-2:0], A[WIDTH-1]}; one_c = A[WIDTH-1]; end
         4'h7: begin one_res = {A[0], A[WIDTH-1:1]}; one_c = A[0]; end
         4'h8: one_res = A & B;
         4'h9: one_res = A | B;
         4'hA: one_res = A ^ B;
         4'hB: one_res = ~(A | B);
         4'hC: one_res = ~(A & B);
         4'hD: one_res = ~(A ^ B);
         4'hE: one_res = {{(WIDTH-1){1'b0}}, (A > B)};
         4'hF: one_res = {{(WIDTH-1){1'b0}}, (A == B)};
         default: one_res = '0;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide.
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      div_sh  = {hi_q, lo_q[WIDTH-1]};
      div_ge  = (div_sh >= {1'b0, b_q});
      if (div_op_q) begin
         // When div_ge holds the true difference is below B, so W bits suffice.
         step_hi = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
         step_lo = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      b_d        = b_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_op_d   = div_op_q;
      out_d      = out_q;
      out_hi_d   = out_hi_q;
      c_d        = c_q;
      zero_d     = zero_q;
      dbz_d      = dbz_q;
      needs_calc = (alu_sel == 4'h2) || ((alu_sel == 4'h3) && (B != '0));
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               b_d      = B;
               hi_d     = '0;
               lo_d     = A;
               div_op_d = (alu_sel == 4'h3);
               if (needs_calc) begin
                  cnt_d   = CW'(WIDTH);
                  state_d = S_CALC;
               end else begin
                  out_d    = one_res;
                  out_hi_d = one_hi;
                  c_d      = one_c;
                  zero_d   = (one_res == '0);
                  dbz_d    = one_dbz;
                  state_d  = S_DONE;
               end
            end
         end
         S_CALC: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               out_d    = step_lo;
               out_hi_d = step_hi;
               c_d      = div_op_q ? 1'b0 : (step_hi != '0);
               zero_d   = (step_lo == '0);
               dbz_d    = 1'b0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         div_op_q <= 1'b0;
         out_q    <= '0;
         out_hi_q <= '0;
         c_q      <= 1'b0;
         zero_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         div_op_q <= div_op_d;
         out_q    <= out_d;
         out_hi_q <= out_hi_d;
         c_q      <= c_d;
         zero_q   <= zero_d;
         dbz_q    <= dbz_d;
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign alu_out     = out_q;
   assign alu_out_hi  = out_hi_q;
   assign c_out       = c_q;
   assign zero        = zero_q;
   assign div_by_zero = dbz_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: op sweep, carry/borrow corners,
// MUL/DIV latency, divide-by-zero, backpressure and mid-operation reset.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A, B;
   logic [3:0]   alu_sel;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] alu_out, alu_out_hi;
   logic         c_out, zero, div_by_zero;
   logic [1:0]   state_dbg;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [3:0]   sel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         c;
      logic         dbz;
      int           lat;
   } vec_t;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .alu_sel(alu_sel),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_out(alu_out), .alu_out_hi(alu_out_hi),
      .c_out(c_out), .zero(zero), .div_by_zero(div_by_zero),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Issue one request, wait for its result, check it; with out_ready high
   // also check the return to IDLE one cycle later.
   task automatic run_op(input vec_t v);
      int lat;
      int busy_bad;
      logic [W-1:0] e;
      @(negedge clk);
      A        = v.a;
      B        = v.b;
      alu_sel  = v.sel;
      in_valid = 1'b1;
      exp_q.push_back(v.lo);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A        = W'($urandom_range(0, 255));
      B        = W'($urandom_range(0, 255));
      alu_sel  = 4'($urandom_range(0, 15));
      lat      = 1;
      busy_bad = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_bad++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk($sformatf("lat_sel%0h", v.sel), lat, v.lat);
      chk($sformatf("busy_ready_sel%0h", v.sel), busy_bad, 0);
      e = exp_q.pop_front();
      chk($sformatf("out_sel%0h_a%0d_b%0d", v.sel, v.a, v.b), alu_out, e);
      chk($sformatf("hi_sel%0h", v.sel), alu_out_hi, v.hi);
      chk($sformatf("c_sel%0h", v.sel), c_out, v.c);
      chk($sformatf("zero_sel%0h", v.sel), zero, (e == '0));
      chk($sformatf("dbz_sel%0h", v.sel), div_by_zero, v.dbz);
      if (out_ready) begin
         @(posedge clk);
         #1;
         chk($sformatf("back_idle_sel%0h", v.sel), {out_valid, in_ready}, 2'b01);
      end
   endtask

   vec_t vecs[$];
   vec_t v;
   logic [W-1:0] hold_lo, hold_hi;
   logic [2:0]   hold_f;
   int           unstable;
   int           stale;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = '0;
      B         = '0;
      alu_sel   = '0;
      #12;
      chk("rst_outs", {alu_out, alu_out_hi, c_out, zero, div_by_zero}, '0);
      chk("rst_hs", {out_valid, in_ready}, 2'b01);
      chk("rst_state", state_dbg, 2'd0);
      @(negedge clk);
      rst = 1'b0;

      // sweep A=10, B=5 (sel, a, b, lo, hi, c, dbz, latency)
      vecs.push_back('{4'h0, 10, 5, 8'd15,   8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'h1, 10, 5, 8'd5,    8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'h2, 10, 5, 8'd50,   8'd0, 1'b0, 1'b0, 9});
      vecs.push_back('{4'h3, 10, 5, 8'd2,    8'd0, 1'b0, 1'b0, 9});
      vecs.push_back('{4'h4, 10, 5, 8'd20,   8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'h5, 10, 5, 8'd5,    8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'h6, 10, 5, 8'd20,   8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'h7, 10, 5, 8'd5,    8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'h8, 10, 5, 8'h00,   8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'h9, 10, 5, 8'h0F,   8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'hA, 10, 5, 8'h0F,   8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'hB, 10, 5, 8'hF0,   8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'hC, 10, 5, 8'hFF,   8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'hD, 10, 5, 8'hF0,   8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'hE, 10, 5, 8'd1,    8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'hF, 10, 5, 8'd0,    8'd0, 1'b0, 1'b0, 1});
      // carry/borrow and shift-out corners
      vecs.push_back('{4'h1, 5, 10,    8'd251, 8'd0, 1'b1, 1'b0, 1});
      vecs.push_back('{4'h0, 200, 100, 8'd44,  8'd0, 1'b1, 1'b0, 1});
      vecs.push_back('{4'h4, 8'h81, 0, 8'h02,  8'd0, 1'b1, 1'b0, 1});
      vecs.push_back('{4'h5, 8'h81, 0, 8'h40,  8'd0, 1'b1, 1'b0, 1});
      vecs.push_back('{4'h6, 8'h81, 0, 8'h03,  8'd0, 1'b1, 1'b0, 1});
      vecs.push_back('{4'h7, 8'h81, 0, 8'hC0,  8'd0, 1'b1, 1'b0, 1});
      vecs.push_back('{4'hE, 5, 10,    8'd0,   8'd0, 1'b0, 1'b0, 1});
      vecs.push_back('{4'hF, 7, 7,     8'd1,   8'd0, 1'b0, 1'b0, 1});
      // multiply / divide
      vecs.push_back('{4'h2, 200, 3,   8'h58,  8'h02, 1'b1, 1'b0, 9});
      vecs.push_back('{4'h2, 255, 255, 8'h01,  8'hFE, 1'b1, 1'b0, 9});
      vecs.push_back('{4'h2, 0, 77,    8'h00,  8'h00, 1'b0, 1'b0, 9});
      vecs.push_back('{4'h3, 100, 7,   8'd14,  8'd2,  1'b0, 1'b0, 9});
      vecs.push_back('{4'h3, 255, 1,   8'd255, 8'd0,  1'b0, 1'b0, 9});
      vecs.push_back('{4'h3, 7, 9,     8'd0,   8'd7,  1'b0, 1'b0, 9});
      vecs.push_back('{4'h3, 10, 0,    8'hFF,  8'd10, 1'b0, 1'b1, 1});
      vecs.push_back('{4'h0, 3, 4,     8'd7,   8'd0,  1'b0, 1'b0, 1});
      foreach (vecs[i]) run_op(vecs[i]);

      // backpressure on a MUL: outputs frozen and no accept while held
      out_ready = 1'b0;
      v = '{4'h2, 200, 3, 8'h58, 8'h02, 1'b1, 1'b0, 9};
      run_op(v);
      hold_lo  = alu_out;
      hold_hi  = alu_out_hi;
      hold_f   = {c_out, zero, div_by_zero};
      unstable = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (alu_out !== hold_lo || alu_out_hi !== hold_hi ||
             {c_out, zero, div_by_zero} !== hold_f || !out_valid || in_ready)
            unstable++;
      end
      chk("bp_stable", unstable, 0);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release", {out_valid, in_ready}, 2'b01);

      // reset during cycle 4 of a MUL
      @(negedge clk);
      A        = 200;
      B        = 3;
      alu_sel  = 4'h2;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", {alu_out, alu_out_hi, c_out, zero, div_by_zero}, '0);
      chk("mid_rst_hs", {out_valid, in_ready}, 2'b01);
      @(posedge clk);
      #3;
      rst   = 1'b0;
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) stale++;
      end
      chk("no_stale", stale, 0);
      v = '{4'h0, 1, 1, 8'd2, 8'd0, 1'b0, 1'b0, 1};
      run_op(v);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the team's 8-bit combinational ALU. Keeps the same 16-operation `alu_sel` encoding. Adds:
- registered outputs with valid/ready handshakes on input and output;
- an iterative shift-add multiplier and a restoring divider that produce double-width results;
- zero and divide-by-zero status flags.

It sits between an operand-issue stage and a result-consuming stage, one operation in flight at a time.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operation request present.
- in_ready  output  1  block can accept a request.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- alu_sel  input  4  operation select.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer accepts the result.
- alu_out  output  WIDTH  primary result.
- alu_out_hi  output  WIDTH  MUL high half / DIV remainder; 0 for all other ops.
- c_out  output  1  carry/borrow/shift-out/overflow, per op.
- zero  output  1  1 when alu_out == 0.
- div_by_zero  output  1  1 when a DIV had B == 0.

## Operation

- FSM states:
  - IDLE: in_ready = 1.
  - CALC: iterative MUL/DIV.
  - DONE: out_valid = 1.
- Accept: in_valid && in_ready at a rising edge. A, B and alu_sel are captured at accept. Input changes after accept are ignored.
- IDLE -> DONE on accept of any op except MUL, and except DIV with B != 0. Result is computed and registered on that edge.
- IDLE -> CALC on accept of MUL, or of DIV with B != 0. Iteration counter loads WIDTH.
- CALC: one shift-add or restore step per cycle. -> DONE when the counter reaches 0, after exactly WIDTH steps.
- DONE -> IDLE on out_ready. No new request is accepted in DONE.
- Outputs are stable in DONE until the handshake completes.
- Ops, unsigned, W = WIDTH:
  - 0000 ADD: {c_out, alu_out} = A + B.
  - 0001 SUB: alu_out = A − B mod 2^W; c_out = (A < B).
  - 0010 MUL: {alu_out_hi, alu_out} = A × B; c_out = (alu_out_hi != 0).
  - 0011 DIV: alu_out = A / B; alu_out_hi = A % B; c_out = 0.
  - 0011 DIV with B == 0: alu_out = all ones; alu_out_hi = A; div_by_zero = 1; no CALC.
  - 0100 LSHIFT: A << 1; c_out = A[W−1].
  - 0101 RSHIFT: A >> 1; c_out = A[0].
  - 0110 ROL: {A[W−2:0], A[W−1]}; c_out = A[W−1].
  - 0111 ROR: {A[0], A[W−1:1]}; c_out = A[0].
  - 1000–1101 AND, OR, XOR, NOR, NAND, XNOR: bitwise; c_out = 0.
  - 1110 GREATER: alu_out = (A > B) ? 1 : 0.
  - 1111 EQUAL: alu_out = (A == B) ? 1 : 0.
- Flags:
  - zero is derived from the registered alu_out.
  - div_by_zero is 0 for every op except DIV with B == 0.
  - All result outputs and flags update only on entry to DONE.

## Timing

- Reset (asynchronous, immediate): state = IDLE; alu_out, alu_out_hi, c_out, zero, div_by_zero, out_valid = 0; in_ready = 1. Counter and operand registers cleared.
- Reset mid-CALC or mid-DONE aborts the operation. The pending result is discarded and never presented.
- in_ready and out_valid are decoded from state register only; no combinational path from any input.
- Latency from accept edge to out_valid high:
  - 1 cycle for single-step ops and DIV by zero.
  - WIDTH+1 cycles for MUL and for DIV with B != 0.
- Throughput with out_ready held high:
  - one single-step op every 2 cycles;
  - one MUL/DIV every WIDTH+2 cycles.
- in_valid asserted while in_ready = 0 has no effect. The requester must hold its request.

## Test plan

- WIDTH=8, A=10, B=5, sweep alu_sel 0..15 with out_ready=1 -> each result matches the op list above. Spot checks:
  - ADD: 15, c_out 0.
  - SUB: 5.
  - ROL: 20.
  - NOR: 0xF0.
  - GREATER: 1.
  - EQUAL: 0, zero = 1.
- SUB A=5, B=10 -> alu_out = 251, c_out = 1. ADD A=200, B=100 -> alu_out = 44, c_out = 1.
- MUL A=200, B=3 -> out_valid exactly 9 cycles after accept; alu_out = 0x58, alu_out_hi = 0x02, c_out = 1. in_ready low throughout.
- DIV A=100, B=7 -> alu_out = 14, alu_out_hi = 2 after 9 cycles. DIV A=10, B=0 -> 1-cycle latency; alu_out = 0xFF, alu_out_hi = 10, div_by_zero = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid on a MUL -> outputs bit-stable and in_ready = 0. Pulse out_ready -> in_ready = 1 next cycle.
- Assert rst for one cycle during cycle 4 of a MUL -> all outputs 0 and in_ready = 1 immediately. A new ADD A=1, B=1 then returns 2, with no stale MUL result presented.
